// File: rtl/pre_decode.sv
// Pre-decode stage between fetch and decode: holds the returned instruction across
// decode stalls and predicts B/BL (and, with PD_BTFN_PREDICT_EN, backward conditional branches).
module pre_decode (
  input  logic        clk,
  input  logic        rstn,
  input  logic        FpD_valid,
  input  logic [42:0] FpD_BUS,
  input  logic [31:0] inst_sram_rdata,
  input  logic        D_allowin,
  input  logic        flush,
  output logic        pD_allowin,
  output logic [32:0] predict_BUS,
  output logic        pDD_valid,
  output logic [74:0] pDD_BUS
);

`ifdef PD_BTFN_PREDICT_EN
  localparam bit BtfnEn = 1'b1;
`else
  localparam bit BtfnEn = 1'b0;
`endif

  logic        pd_valid;
  logic        fresh;
  logic        buf_valid;
  logic [31:0] pc;
  logic [31:0] inst_buf;
  logic        ex;
  logic [7:0]  ecode;
  logic        esubcode;

  logic        accept;
  logic [31:0] inst;
  logic [5:0]  opcode;
  logic        is_b;
  logic        is_cond;
  logic        is_pred;
  logic [31:0] b_offs;
  logic [31:0] cond_offs;
  logic [31:0] target;
  logic        predict_taken;

  assign pD_allowin = !pd_valid || D_allowin;
  assign accept     = pD_allowin && FpD_valid && FpD_BUS[10];

  // NOTE: reset is synchronous and wins over accept/flush; all state uses non-blocking updates.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pd_valid  <= 1'b0;
      fresh     <= 1'b0;
      buf_valid <= 1'b0;
      pc        <= '0;
      inst_buf  <= '0;
      ex        <= 1'b0;
      ecode     <= '0;
      esubcode  <= 1'b0;
    end else begin
      fresh <= accept;
      if (accept) begin
        pd_valid <= 1'b1;
        pc       <= FpD_BUS[42:11];
        ex       <= FpD_BUS[9];
        ecode    <= FpD_BUS[8:1];
        esubcode <= FpD_BUS[0];
      end else if (D_allowin || flush) begin
        pd_valid <= 1'b0;
      end
      // The SRAM word is only valid in the cycle after the fetch; keep it if decode stalls.
      if (fresh && pd_valid && !D_allowin && !flush) begin
        buf_valid <= 1'b1;
        inst_buf  <= inst_sram_rdata;
      end else if (D_allowin || flush) begin
        buf_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    inst      = ex ? 32'd0 : (buf_valid ? inst_buf : inst_sram_rdata);
    opcode    = inst[31:26];
    is_b      = (opcode == 6'b010100) || (opcode == 6'b010101);
    is_cond   = (opcode >= 6'b010110) && (opcode <= 6'b011011);
    b_offs    = {{4{inst[9]}}, inst[9:0], inst[25:10], 2'b00};
    cond_offs = {{14{inst[25]}}, inst[25:10], 2'b00};
    // Static backward-taken/forward-not-taken for conditional branches when enabled.
    is_pred   = is_b || (is_cond && inst[25] && BtfnEn);
    target    = pc + (is_b ? b_offs : cond_offs);
    // Redirect only when the entry hands off this edge, so each instruction predicts once.
    predict_taken = pd_valid && D_allowin && !flush && !ex && is_pred;
    predict_BUS   = predict_taken ? {1'b1, target} : 33'd0;
  end

  assign pDD_valid = pd_valid && !flush;
  assign pDD_BUS   = {pc, inst, predict_taken, ex, ecode, esubcode};

endmodule

// File: tb/tb_pre_decode.sv
// Directed bench for pre_decode: prediction, stall buffering, flush redirect, exceptions.
module tb_pre_decode;
  logic        clk;
  logic        rstn;
  logic        FpD_valid;
  logic [42:0] FpD_BUS;
  logic [31:0] inst_sram_rdata;
  logic        D_allowin;
  logic        flush;
  logic        pD_allowin;
  logic [32:0] predict_BUS;
  logic        pDD_valid;
  logic [74:0] pDD_BUS;

  int n_tests = 0;
  int n_fail  = 0;

  pre_decode dut (
    .clk            (clk),
    .rstn           (rstn),
    .FpD_valid      (FpD_valid),
    .FpD_BUS        (FpD_BUS),
    .inst_sram_rdata(inst_sram_rdata),
    .D_allowin      (D_allowin),
    .flush          (flush),
    .pD_allowin     (pD_allowin),
    .predict_BUS    (predict_BUS),
    .pDD_valid      (pDD_valid),
    .pDD_BUS        (pDD_BUS)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [74:0] obs, input logic [74:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [74:0] pdd(input logic [31:0] pc, input logic [31:0] inst,
                                      input logic pred, input logic ex,
                                      input logic [7:0] ecode, input logic esub);
    return {pc, inst, pred, ex, ecode, esub};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one fetch entry for a cycle, then drop FpD_valid.
  task automatic issue(input logic [31:0] pc, input logic ex, input logic [7:0] ecode);
    FpD_valid = 1'b1;
    FpD_BUS   = {pc, 1'b1, ex, ecode, 1'b0};
    tick();
    FpD_valid = 1'b0;
  endtask

  logic [31:0] b_neg4, beq_p8, bne_m2, bl_p8, jirl_i, b_p1;
  logic        exp_bne_pred;

  initial begin
    b_neg4 = {6'b010100, 16'hfffc, 10'h3ff};
    beq_p8 = {6'b010110, 16'h0008, 5'd2, 5'd1};
    bne_m2 = {6'b010111, 16'hfffe, 5'd2, 5'd1};
    bl_p8  = {6'b010101, 16'h0008, 10'h000};
    jirl_i = {6'b010011, 16'hfffc, 5'd1, 5'd1};
    b_p1   = {6'b010100, 16'h0001, 10'h000};
`ifdef PD_BTFN_PREDICT_EN
    exp_bne_pred = 1'b1;
`else
    exp_bne_pred = 1'b0;
`endif

    // Reset overrides a pending accept and flush.
    rstn = 1'b0; flush = 1'b1; D_allowin = 1'b1; inst_sram_rdata = '0;
    FpD_valid = 1'b1; FpD_BUS = {32'h1c000010, 1'b1, 1'b0, 8'h00, 1'b0};
    tick(); tick();
    @(negedge clk);
    check("rst_pdd_valid", pDD_valid, 0);
    check("rst_predict", predict_BUS, 0);
    check("rst_allowin", pD_allowin, 1);
    check("rst_pdd_bus", pDD_BUS, 0);
    rstn = 1'b1; flush = 1'b0; FpD_valid = 1'b0;
    tick();
    @(negedge clk);
    check("idle_pdd_valid", pDD_valid, 0);

    // B backward
    issue(32'h1c000010, 1'b0, 8'h00);
    inst_sram_rdata = b_neg4;
    @(negedge clk);
    check("b_predict", predict_BUS, {1'b1, 32'h1c000000});
    check("b_pdd_bus", pDD_BUS, pdd(32'h1c000010, b_neg4, 1'b1, 1'b0, 8'h00, 1'b0));
    check("b_pdd_valid", pDD_valid, 1);

    // BEQ forward: never predicted
    issue(32'h1c000020, 1'b0, 8'h00);
    inst_sram_rdata = beq_p8;
    @(negedge clk);
    check("beq_predict", predict_BUS, 0);
    check("beq_pdd_bus", pDD_BUS, pdd(32'h1c000020, beq_p8, 1'b0, 1'b0, 8'h00, 1'b0));

    // BNE backward: depends on the build
    issue(32'h1c000030, 1'b0, 8'h00);
    inst_sram_rdata = bne_m2;
    @(negedge clk);
    check("bne_predict", predict_BUS, exp_bne_pred ? {1'b1, 32'h1c000028} : 33'd0);
    check("bne_pdd_bus", pDD_BUS, pdd(32'h1c000030, bne_m2, exp_bne_pred, 1'b0, 8'h00, 1'b0));

    // BL with target wrapping past 2^32
    issue(32'hfffffff0, 1'b0, 8'h00);
    inst_sram_rdata = bl_p8;
    @(negedge clk);
    check("bl_wrap_predict", predict_BUS, {1'b1, 32'h00000010});

    // JIRL is never predicted
    issue(32'h1c000050, 1'b0, 8'h00);
    inst_sram_rdata = jirl_i;
    @(negedge clk);
    check("jirl_predict", predict_BUS, 0);
    check("jirl_pred_bit", pDD_BUS[10], 0);

    // Three-cycle decode stall: buffered word must hold against changing rdata
    issue(32'h1c000040, 1'b0, 8'h00);
    inst_sram_rdata = 32'h02800000;
    D_allowin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_pdd_bus", pDD_BUS, pdd(32'h1c000040, 32'h02800000, 1'b0, 1'b0, 8'h00, 1'b0));
      check("stall_pdd_valid", pDD_valid, 1);
      check("stall_allowin", pD_allowin, 0);
      tick();
      inst_sram_rdata = 32'hdeadbeef;
    end

    // Flush with the redirect target accepted in the same cycle
    flush = 1'b1; D_allowin = 1'b1;
    FpD_valid = 1'b1; FpD_BUS = {32'h1c000100, 1'b1, 1'b0, 8'h00, 1'b0};
    @(negedge clk);
    check("flush_pdd_valid", pDD_valid, 0);
    check("flush_predict", predict_BUS, 0);
    check("flush_allowin", pD_allowin, 1);
    tick();
    flush = 1'b0; FpD_valid = 1'b0; inst_sram_rdata = 32'h12345678;
    @(negedge clk);
    check("redirect_pdd_valid", pDD_valid, 1);
    check("redirect_pdd_bus", pDD_BUS, pdd(32'h1c000100, 32'h12345678, 1'b0, 1'b0, 8'h00, 1'b0));

    // B stalled one cycle: no prediction until handoff, then taken from buffer
    issue(32'h1c000300, 1'b0, 8'h00);
    inst_sram_rdata = b_p1;
    D_allowin = 1'b0;
    @(negedge clk);
    check("bstall_predict", predict_BUS, 0);
    tick();
    inst_sram_rdata = 32'h0;
    D_allowin = 1'b1;
    @(negedge clk);
    check("bstall_release_predict", predict_BUS, {1'b1, 32'h1c000304});
    check("bstall_release_bus", pDD_BUS, pdd(32'h1c000300, b_p1, 1'b1, 1'b0, 8'h00, 1'b0));

    // Exception entry: inst forced to zero, no prediction
    issue(32'h1c000200, 1'b1, 8'h08);
    inst_sram_rdata = b_neg4;
    @(negedge clk);
    check("ex_predict", predict_BUS, 0);
    check("ex_pdd_bus", pDD_BUS, pdd(32'h1c000200, 32'h0, 1'b0, 1'b1, 8'h08, 1'b0));
    check("ex_pdd_valid", pDD_valid, 1);

    // pc_en low: nothing accepted
    FpD_valid = 1'b1; FpD_BUS = {32'h1c000400, 1'b0, 1'b0, 8'h00, 1'b0};
    tick();
    FpD_valid = 1'b0;
    @(negedge clk);
    check("pcen_pdd_valid", pDD_valid, 0);
    check("pcen_allowin", pD_allowin, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pre_decode.md
PRE_DECODE -- requirements
Module: pre_decode

Interface
REQ-001 SHALL have: clk  in  1  clock; rstn  in  1  reset, synchronous, active-low.
REQ-002 SHALL have: FpD_valid  in  1  fetch-side valid.
REQ-003 SHALL have: FpD_BUS  in  43  {pc[42:11], pc_en[10], ex_F[9], ecode[8:1], esubcode[0]}.
REQ-004 SHALL have: inst_sram_rdata  in  32  instruction word, returned one cycle after the address is issued.
REQ-005 SHALL have: D_allowin  in  1  decode stage can accept.
REQ-006 SHALL have: flush  in  1  OR of branch-taken, exception, and ertn redirect.
REQ-007 SHALL have: pD_allowin  out  1  this stage can accept.
REQ-008 SHALL have: predict_BUS  out  33  {predict_taken[32], predict_target[31:0]}.
REQ-009 SHALL have: pDD_valid  out  1  valid to decode.
REQ-010 SHALL have: pDD_BUS  out  75  {pc[74:43], inst[42:11], predicted[10], ex[9], ecode[8:1], esubcode[0]}.

Function
REQ-011 SHALL compute pD_ready_go = 1 and pD_allowin = !pD_valid || D_allowin.
REQ-012 SHALL accept an entry when pD_allowin && FpD_valid && pc_en: latch pc/ex/ecode/esubcode, set pD_valid and fresh; otherwise clear pD_valid when D_allowin is high.
REQ-013 SHALL clear fresh one cycle after it is set.
REQ-014 SHALL select inst = buf_valid ? inst_buf : inst_sram_rdata.
REQ-015 SHALL set buf_valid and capture inst_buf <= inst_sram_rdata when fresh && pD_valid && !D_allowin && !flush.
REQ-016 SHALL hold inst_buf until the entry leaves (D_allowin) or flush, then clear buf_valid.
REQ-017 SHALL drive pDD_valid = pD_valid && !flush.
REQ-018 SHALL, on flush, clear pD_valid and buf_valid next edge, except that an entry accepted in the same cycle (the redirect target) SHALL be latched valid.
REQ-019 SHALL decode B (inst[31:26]=010100) and BL (010101) as targets pc + sext({inst[9:0],inst[25:10]},2'b00), always predicted taken.
REQ-020 SHALL decode BEQ/BNE/BLT/BGE/BLTU/BGEU (010110..011011) as targets pc + sext({inst[25:10],2'b00}); prediction per REQ-028.
REQ-021 SHALL not predict JIRL or any other opcode.
REQ-022 SHALL assert predict_taken only when pD_valid && D_allowin && !flush && !ex && the instruction is predicted; otherwise predict_BUS = 0.
REQ-023 SHALL use 32-bit wrap-around addition for targets (carry discarded).
REQ-024 SHALL set the predicted bit of pDD_BUS equal to predict_taken.
REQ-025 SHALL pass ex, ecode, and esubcode through unchanged; for ex=1 it SHALL force inst to 0.
REQ-026 SHALL assert predict_taken for exactly one cycle per instruction, because the handoff to decode and the fetch redirect occur on the same edge.

Reset
REQ-027 SHALL on rstn=0 clear pD_valid, fresh, buf_valid, latched pc, inst_buf, and ex fields; pDD_valid=0, predict_BUS=0, pD_allowin=1; reset overrides flush and accept.

Configuration
REQ-028 SHALL, with PD_BTFN_PREDICT_EN defined, predict conditional branches taken iff the offset sign bit inst[25]=1 (backward); without it, it SHALL never predict conditional branches, and B/BL behaviour is unchanged.

Verification
REQ-029 SHALL cover: accept pc 0x1c000010 holding B with offs26=-4, D_allowin=1 -> predict_BUS={1,0x1c000000}, pDD_BUS pc=0x1c000010, predicted=1.
REQ-030 SHALL cover: BEQ at 0x1c000020 with offs16=+8 -> predict_taken=0, inst passed, predicted=0.
REQ-031 SHALL cover: BNE at 0x1c000030 with offs16=-2 -> macro defined: {1,0x1c000028}; macro undefined: predict_taken=0.
REQ-032 SHALL cover: accept 0x1c000040 with rdata 0x02800000, D_allowin=0 for 3 cycles, rdata then 0xdeadbeef -> pDD inst stays 0x02800000, pDD_valid=1, pD_allowin=0 throughout.
REQ-033 SHALL cover: flush=1 during the REQ-032 stall with a new accept at 0x1c000100 -> pDD_valid=0 that cycle, buf cleared, next cycle pc=0x1c000100 valid, inst taken from rdata.
REQ-034 SHALL cover: accept with ex_F=1, ecode 0x08, rdata holding a B -> predict_taken=0, inst=0, ex=1, ecode=0x08.
